// File: rtl/pe_operand_feeder.sv
// Operand feeder for the convolution PE: loads K filter taps and a K-wide
// ifmap window, then streams stride-1 1-D row convolution operand pairs.
module pe_operand_feeder #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_K      = 8,
  parameter int LEN_W      = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [LEN_W-1:0]      cfg_k,
  input  logic [LEN_W-1:0]      cfg_out_len,
  input  logic                  fltr_in_valid,
  input  logic [DATA_WIDTH-1:0] fltr_in_data,
  output logic                  fltr_in_ready,
  input  logic                  ifmap_in_valid,
  input  logic [DATA_WIDTH-1:0] ifmap_in_data,
  output logic                  ifmap_in_ready,
  output logic [DATA_WIDTH-1:0] ifmap_data_o,
  output logic [DATA_WIDTH-1:0] fltr_data_o,
  output logic                  pe_valid,
  output logic                  acc_seln,
  output logic                  mult_seln,
  output logic                  psum_last,
  output logic                  busy,
  output logic                  done
);

  localparam int IW = (MAX_K > 1) ? $clog2(MAX_K) : 1;
  localparam logic [IW-1:0]    I_ONE = IW'(1);
  localparam logic [IW:0]      W_ONE = (IW+1)'(1);
  localparam logic [LEN_W-1:0] L_ONE = LEN_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_F, S_LOAD_X, S_COMPUTE, S_SHIFT, S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          k_last_q, k_last_d;
  logic [LEN_W-1:0]       n_last_q, n_last_d;
  logic [IW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          base_q, base_d;
  logic [IW-1:0]          kidx_q, kidx_d;
  logic [LEN_W-1:0]       j_q, j_d;
  logic [DATA_WIDTH-1:0]  ifmap_q, ifmap_d;
  logic [DATA_WIDTH-1:0]  fltr_q, fltr_d;
  logic                   valid_q, valid_d;
  logic                   acc_q, acc_d;
  logic                   last_q, last_d;
  logic                   done_q, done_d;

  logic [DATA_WIDTH-1:0]  w_q [MAX_K];
  logic [DATA_WIDTH-1:0]  x_q [MAX_K];

  logic                   f_hs, x_hs, cfg_ok;
  logic [IW:0]            win_sum;
  logic [IW-1:0]          win_idx, x_wr_idx;

  assign fltr_in_ready  = (state_q == S_LOAD_F);
  assign ifmap_in_ready = (state_q == S_LOAD_X) || (state_q == S_SHIFT);
  assign f_hs           = fltr_in_valid & fltr_in_ready;
  assign x_hs           = ifmap_in_valid & ifmap_in_ready;
  assign cfg_ok         = (cfg_k != '0) && (cfg_k <= LEN_W'(MAX_K)) && (cfg_out_len != '0);

  // Window is circular: oldest sample lives at slot base, so tap k reads (base+k) mod K.
  assign win_sum  = {1'b0, base_q} + {1'b0, kidx_q};
  assign win_idx  = (win_sum > {1'b0, k_last_q}) ? IW'(win_sum - {1'b0, k_last_q} - W_ONE)
                                                 : win_sum[IW-1:0];
  assign x_wr_idx = (state_q == S_SHIFT) ? base_q : cnt_q;

  always_comb begin
    state_d  = state_q;
    k_last_d = k_last_q;
    n_last_d = n_last_q;
    cnt_d    = cnt_q;
    base_d   = base_q;
    kidx_d   = kidx_q;
    j_d      = j_q;
    ifmap_d  = '0;
    fltr_d   = '0;
    valid_d  = 1'b0;
    acc_d    = 1'b0;
    last_d   = 1'b0;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && cfg_ok) begin
          k_last_d = IW'(cfg_k - L_ONE);
          n_last_d = cfg_out_len - L_ONE;
          cnt_d    = '0;
          state_d  = S_LOAD_F;
        end
      end
      S_LOAD_F: begin
        if (f_hs) begin
          if (cnt_q == k_last_q) begin
            cnt_d   = '0;
            state_d = S_LOAD_X;
          end else begin
            cnt_d = cnt_q + I_ONE;
          end
        end
      end
      S_LOAD_X: begin
        if (x_hs) begin
          if (cnt_q == k_last_q) begin
            cnt_d   = '0;
            base_d  = '0;
            kidx_d  = '0;
            j_d     = '0;
            state_d = S_COMPUTE;
          end else begin
            cnt_d = cnt_q + I_ONE;
          end
        end
      end
      S_COMPUTE: begin
        valid_d = 1'b1;
        ifmap_d = x_q[win_idx];
        fltr_d  = w_q[kidx_q];
        acc_d   = (kidx_q == '0);
        last_d  = (kidx_q == k_last_q);
        if (kidx_q == k_last_q) begin
          kidx_d = '0;
          if (j_q == n_last_q) begin
            state_d = S_DONE;
          end else begin
            j_d     = j_q + L_ONE;
            state_d = S_SHIFT;
          end
        end else begin
          kidx_d = kidx_q + I_ONE;
        end
      end
      S_SHIFT: begin
        if (x_hs) begin
          base_d  = (base_q == k_last_q) ? '0 : base_q + I_ONE;
          state_d = S_COMPUTE;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      k_last_q <= '0;
      n_last_q <= '0;
      cnt_q    <= '0;
      base_q   <= '0;
      kidx_q   <= '0;
      j_q      <= '0;
      ifmap_q  <= '0;
      fltr_q   <= '0;
      valid_q  <= 1'b0;
      acc_q    <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_last_q <= k_last_d;
      n_last_q <= n_last_d;
      cnt_q    <= cnt_d;
      base_q   <= base_d;
      kidx_q   <= kidx_d;
      j_q      <= j_d;
      ifmap_q  <= ifmap_d;
      fltr_q   <= fltr_d;
      valid_q  <= valid_d;
      acc_q    <= acc_d;
      last_q   <= last_d;
      done_q   <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (f_hs) w_q[cnt_q]    <= fltr_in_data;
    if (x_hs) x_q[x_wr_idx] <= ifmap_in_data;
  end

  assign ifmap_data_o = ifmap_q;
  assign fltr_data_o  = fltr_q;
  assign pe_valid     = valid_q;
  assign mult_seln    = valid_q;
  assign acc_seln     = acc_q;
  assign psum_last    = last_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;

endmodule

// File: doc/pe_operand_feeder.md
Name: pe_operand_feeder

Overview:
- Upstream stage of the convolution PE: a filter/ifmap scratchpad with a sequencer that performs stride-1 1-D row convolution.
- Loads K filter taps and a sliding K-wide ifmap window from the buffer side (valid/ready).
- Streams one (ifmap, filter) operand pair per cycle into the PE, with the PE accumulator control (acc_seln, mult_seln) and framing flags.
- Output j corresponds to sum over k of w[k]*x[j+k].

Parameters:
- DATA_WIDTH, 16, width of ifmap and filter words.
- MAX_K, 8, scratchpad depth; maximum kernel length.
- LEN_W, 8, width of the kernel-length and output-count config fields.

Ports:
- clk  input  1  system clock.
- rstn  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; latches the config and begins a row; ignored unless IDLE.
- cfg_k  input  LEN_W  kernel length K, legal range 1..MAX_K.
- cfg_out_len  input  LEN_W  number of outputs N, legal range >= 1.
- fltr_in_valid  input  1  filter word valid.
- fltr_in_data  input  DATA_WIDTH  filter word.
- fltr_in_ready  output  1  feeder accepts a filter word.
- ifmap_in_valid  input  1  ifmap word valid.
- ifmap_in_data  input  DATA_WIDTH  ifmap word.
- ifmap_in_ready  output  1  feeder accepts an ifmap word.
- ifmap_data_o  output  DATA_WIDTH  operand to PE multiplier input a.
- fltr_data_o  output  DATA_WIDTH  operand to PE multiplier input b.
- pe_valid  output  1  operand pair valid this cycle.
- acc_seln  output  1  1 on the first pair of each output (clear accumulator feedback).
- mult_seln  output  1  1 whenever pe_valid=1; 0 otherwise.
- psum_last  output  1  1 on the final pair of each output.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse after the last pair of the row.

Behaviour:
- Reset (async, rstn=0): all outputs 0, state IDLE, pointers and counters 0; the scratchpad contents need not be reset.
- All PE-facing outputs are registered. A pair is presented the cycle after it is sequenced. There is no PE backpressure.
- Config: start in IDLE latches cfg_k→K and cfg_out_len→N. Illegal K (0 or >MAX_K) or N=0: ignore start and stay IDLE.
- LOAD_F state:
  - fltr_in_ready=1.
  - Each handshake writes w[cnt] and increments cnt.
  - After K words go to LOAD_X and clear cnt.
- LOAD_X state:
  - ifmap_in_ready=1.
  - Writes x[cnt] into circular window slot cnt.
  - After K words go to COMPUTE with base=0, k=0, j=0.
- COMPUTE state:
  - Each cycle emits pair (x[(base+k) mod K], w[k]) with pe_valid=1.
  - acc_seln=(k==0); psum_last=(k==K-1).
  - When k==K-1:
    - if j==N-1, go to DONE;
    - else j++, k=0, go to SHIFT.
- SHIFT state:
  - ifmap_in_ready=1, pe_valid=0.
  - Waits any number of cycles for valid.
  - On handshake, overwrite slot base with the new word, base=(base+1) mod K, go to COMPUTE.
- DONE state: pulse done=1 for one cycle, then IDLE.
- K=1: every pair has both acc_seln=1 and psum_last=1.
- fltr/ifmap ready are never asserted outside their states. Input data presented while not ready is not consumed.
- start while busy is ignored; the in-flight row completes unaffected.
- Reset mid-row: immediate return to IDLE; all handshakes drop; no partial done.
- Throughput: one row takes K + K + N*K + (N-1) + 1 cycles minimum (no source stalls).

Test Plan:
- K=3, N=2, w={1,2,3}, x={4,5,6,7}, no stalls. Required: pairs (4,1)(5,2)(6,3) then (5,1)(6,2)(7,3); acc_seln on the 1st and 4th pair; psum_last on the 3rd and 6th pair; single done; busy low afterwards.
- K=1, N=4, w={2}, x={1,2,3,4}: each pair carries acc_seln=psum_last=1; ifmap operands arrive in order 1,2,3,4.
- SHIFT stall: ifmap_in_valid low for 5 cycles before the 2nd output. Required: pe_valid=0 throughout the stall, ifmap_in_ready=1, then the correct window resumes.
- start pulsed during COMPUTE, and cfg_k=0 start pulsed in IDLE: both ignored; no ready asserted for the illegal start.
- rstn asserted mid-COMPUTE: all outputs 0 asynchronously and no done. A new start with K=2, N=1 then completes correctly.
- K=MAX_K=8, N=3, wrap-around: base wraps 0→1→2; operand order matches the software reference model.
